sq_window_accum: RTL and testbench
==================================

Name: sq_window_accum

Overview:
Downstream consumer of the 8-bit unsigned squaring multiplier stage. It takes the 16-bit squared samples and sums them over a fixed power-of-2 window. Per window it produces the sum of squares and the mean power. The multiplier carries no valid signal, so this block delays the upstream sample-valid to match the multiplier pipeline latency. The result is presented on a single-entry valid/ready output register.

Parameters:
MUL_LAT, 3, multiplier pipeline latency in clk cycles (legal range 1..8); depth of the valid delay line.
WIN_LOG2, 4, log2 of window length N (N = 16 by default; legal range 1..8).
DATA_W, 16, squared-sample width.
SUM_W, DATA_W+WIN_LOG2 (derived, not overridable), accumulator/sum width.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid_i  in  1  sample valid, aligned with the multiplier's input sample (not its output)
sq_data_i  in  DATA_W  squared sample straight from the multiplier output P
clear_i  in  1  synchronous flush of the partial window
sum_o  out  SUM_W  registered window sum of squares
mean_o  out  DATA_W  registered sum_o >> WIN_LOG2 (truncating)
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream accepts result
overflow_o  out  1  sticky: a completed result was overwritten before being accepted

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst). On rst, everything below clears to 0: valid delay line, accumulator, sample counter, sum_o, mean_o, out_valid_o and overflow_o. rst mid-window discards the partial sum.
- Valid alignment: in_valid_i is shifted through MUL_LAT registers to form sq_valid. sq_data_i is sampled only when sq_valid = 1.
- Accumulator, on sq_valid with cnt < N-1: acc <= acc + sq_data_i and cnt <= cnt + 1.
- Window completion, on sq_valid with cnt == N-1:
  - total = acc + sq_data_i is loaded into sum_o, with mean_o = total[SUM_W-1:WIN_LOG2].
  - acc <= 0 and cnt <= 0.
- Width: SUM_W bits cannot overflow, since N*(2^DATA_W - 1) < 2^SUM_W. Arithmetic is unsigned, with no saturation.
- Output FSM has two states:
  - EMPTY: out_valid_o = 0. Go to FULL on window completion.
  - FULL: out_valid_o = 1; sum_o and mean_o hold stable.
    - out_ready_i = 1 with no completion that cycle: go to EMPTY.
    - Completion in the same cycle as an accepted handshake: load the new result, stay FULL, no overflow.
    - Completion while out_ready_i = 0: overwrite with the new result, stay FULL, set overflow_o = 1.
- overflow_o is cleared only by rst.
- Latency: in_valid_i of the N-th sample of a window to out_valid_o = 1 is MUL_LAT+1 cycles. Throughput is one sample per cycle, with no input stall capability.
- clear_i:
  - Zeroes acc, cnt and the valid delay line in the same cycle. Samples in flight in the multiplier are discarded.
  - Takes priority over a simultaneous sq_valid; that sample is dropped.
  - Does not touch the output register, out_valid_o or overflow_o.
- rst takes priority over clear_i.

Decomposition:
- Shared package sq_accum_pkg holds:
  - the default constants for WIN_LOG2 and MUL_LAT;
  - the function sum_width(data_w, win_log2) returning data_w + win_log2;
  - the localparam encoding of the output FSM states EMPTY=0 and FULL=1.
- One sub-module, valid_delay_line: a parameterised DEPTH x 1-bit shift register with synchronous rst and flush. It is reusable for aligning other IP-core pipelines.

Test Plan:
The bench places the squaring multiplier wrapper (or a MUL_LAT=3 behavioural model) directly upstream and drives the 8-bit samples together with in_valid_i. Default parameters are used throughout.
1. Constant 3 for 16 consecutive valid cycles, out_ready_i = 1 -> one out_valid_o pulse 4 cycles after the 16th in_valid_i; sum_o = 144, mean_o = 9.
2. Ramp 0..15 with gaps (in_valid_i low every other cycle) -> sum_o = 1240, mean_o = 77; no result produced before the 16th valid sample.
3. Constant 255 for 16 samples -> sum_o = 1040400, mean_o = 65025 (full-scale, no wrap).
4. out_ready_i held low for two back-to-back windows (1s, then 2s) -> after the second completion: out_valid_o = 1, sum_o = 64, mean_o = 4, overflow_o = 1. Raising out_ready_i for one cycle -> out_valid_o = 0; overflow_o remains 1.
5. Send 10 samples of 5, then assert clear_i in the same cycle as the sq_valid of the 10th, then 16 samples of 1 -> sum_o = 16, mean_o = 1. The earlier sums of 250 and 225 never appear on the output.
6. Assert rst for 1 cycle after 7 samples while a prior result is FULL and overflow_o = 1 -> all outputs 0 on the next cycle. A following 16-sample window of 2s gives sum_o = 64.

Source files
------------

// File: rtl/sq_window_accum_pkg.sv
// Shared constants, sum-width helper and output FSM encoding for the
// squared-sample window accumulator.
package sq_accum_pkg;

  localparam int WIN_LOG2_DEF = 4;
  localparam int MUL_LAT_DEF  = 3;

  function automatic int sum_width(input int data_w, input int win_log2);
    return data_w + win_log2;
  endfunction

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/sq_window_accum_if.sv
// Sample input and result output bundle of the window accumulator.
interface sq_window_accum_if
  import sq_accum_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int WIN_LOG2 = WIN_LOG2_DEF
);
  localparam int SUM_W = sum_width(DATA_W, WIN_LOG2);

  logic              in_valid_i;
  logic [DATA_W-1:0] sq_data_i;
  logic              clear_i;
  logic [SUM_W-1:0]  sum_o;
  logic [DATA_W-1:0] mean_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic              overflow_o;

  modport slave (
    input  in_valid_i, sq_data_i, clear_i, out_ready_i,
    output sum_o, mean_o, out_valid_o, overflow_o
  );

  modport master (
    output in_valid_i, sq_data_i, clear_i, out_ready_i,
    input  sum_o, mean_o, out_valid_o, overflow_o
  );
endinterface

// File: rtl/sq_window_accum_valid_delay_line.sv
// DEPTH x 1-bit shift register with synchronous reset and flush; used to
// realign a valid strobe with a pipeline that carries no valid of its own.
module valid_delay_line #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic d_i,
  output logic q_o
);
  logic [DEPTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = d_i;
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/sq_window_accum.sv
// Sums 2**WIN_LOG2 squared samples per window and presents sum and mean on a
// single-entry valid/ready register; unaccepted results are overwritten.
module sq_window_accum
  import sq_accum_pkg::*;
#(
  parameter int MUL_LAT  = MUL_LAT_DEF,
  parameter int WIN_LOG2 = WIN_LOG2_DEF,
  parameter int DATA_W   = 16
) (
  input logic               clk,
  input logic               rst,
  sq_window_accum_if.slave  bus
);
  localparam int SUM_W = sum_width(DATA_W, WIN_LOG2);
  localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;

  logic                sq_valid;
  logic                take;
  logic                complete;
  logic                accept;
  logic [SUM_W-1:0]    total;

  logic [SUM_W-1:0]    acc_q, acc_d;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [DATA_W-1:0]   mean_q, mean_d;
  logic                ovf_q, ovf_d;
  out_state_e          state_q, state_d;

  valid_delay_line #(.DEPTH(MUL_LAT)) u_vdl (
    .clk     (clk),
    .rst     (rst),
    .flush_i (bus.clear_i),
    .d_i     (bus.in_valid_i),
    .q_o     (sq_valid)
  );

  // clear_i wins over a sample landing in the same cycle
  assign take     = sq_valid && !bus.clear_i;
  assign complete = take && (cnt_q == CNT_LAST);
  assign total    = acc_q + {{WIN_LOG2{1'b0}}, bus.sq_data_i};
  assign accept   = (state_q == ST_FULL) && bus.out_ready_i;

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    mean_d = mean_q;
    if (bus.clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (complete) begin
      acc_d  = '0;
      cnt_d  = '0;
      sum_d  = total;
      mean_d = total[SUM_W-1:WIN_LOG2];
    end else if (take) begin
      acc_d = total;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_EMPTY: if (complete) state_d = ST_FULL;
      ST_FULL: begin
        if (complete) begin
          state_d = ST_FULL;
          if (!bus.out_ready_i) ovf_d = 1'b1;
        end else if (accept) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ovf_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      mean_q  <= '0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      mean_q  <= mean_d;
    end
  end

  assign bus.sum_o       = sum_q;
  assign bus.mean_o      = mean_q;
  assign bus.out_valid_o = (state_q == ST_FULL);
  assign bus.overflow_o  = ovf_q;
endmodule

// File: tb/tb_sq_window_accum.sv
// Directed bench: behavioural 3-stage squaring multiplier feeding sq_window_accum.
module tb_sq_window_accum;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a   = 8'd0;
  logic [15:0] p1 = '0, p2 = '0, p3 = '0;
  int checks = 0;
  int errors = 0;

  sq_window_accum_if #(.DATA_W(16), .WIN_LOG2(4)) bus ();

  sq_window_accum u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    p1 <= {8'd0, a} * {8'd0, a};
    p2 <= p1;
    p3 <= p2;
  end
  assign bus.sq_data_i = p3;

  task automatic cyc(input logic v, input logic [7:0] val, input logic clr);
    bus.in_valid_i = v;
    a              = val;
    bus.clear_i    = clr;
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    bus.clear_i    = 1'b0;
  endtask

  task automatic wait_out(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (bus.out_valid_o) seen = 1'b1;
      else cyc(1'b0, 8'd0, 1'b0);
    end
  endtask

  task automatic test_reset;
    bus.in_valid_i  = 1'b0;
    bus.clear_i     = 1'b0;
    bus.out_ready_i = 1'b1;
    rst = 1'b1;
    cyc(1'b0, 8'd0, 1'b0);
    cyc(1'b0, 8'd0, 1'b0);
    rst = 1'b0;
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d exp 0", bus.out_valid_o); end
    checks++; if (bus.sum_o !== 20'd0) begin errors++; $display("FAIL reset_sum got %0d exp 0", bus.sum_o); end
    checks++; if (bus.mean_o !== 16'd0) begin errors++; $display("FAIL reset_mean got %0d exp 0", bus.mean_o); end
    checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0d exp 0", bus.overflow_o); end
  endtask

  task automatic test_const3_latency;
    bit early = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'd3, 1'b0);
      if (bus.out_valid_o) early = 1'b1;
    end
    // cycle index k counts cycles after the one carrying the 16th in_valid
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) cyc(1'b0, 8'd0, 1'b0);
      checks++;
      if (bus.out_valid_o !== (k == 4)) begin
        errors++; $display("FAIL lat_valid_k%0d got %0d exp %0d", k, bus.out_valid_o, (k == 4));
      end
      if (k == 4) begin
        checks++; if (bus.sum_o !== 20'd144) begin errors++; $display("FAIL c3_sum got %0d exp 144", bus.sum_o); end
        checks++; if (bus.mean_o !== 16'd9) begin errors++; $display("FAIL c3_mean got %0d exp 9", bus.mean_o); end
      end
    end
    checks++; if (early) begin errors++; $display("FAIL c3_early got 1 exp 0"); end
  endtask

  task automatic test_ramp_gaps;
    bit early = 1'b0;
    bit seen;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      if (bus.out_valid_o) early = 1'b1;
      cyc(1'b0, 8'd0, 1'b0);
      if (bus.out_valid_o) early = 1'b1;
    end
    checks++; if (early) begin errors++; $display("FAIL ramp_early got 1 exp 0"); end
    wait_out(seen);
    checks++; if (!seen) begin errors++; $display("FAIL ramp_timeout got 0 exp 1"); end
    checks++; if (bus.sum_o !== 20'd1240) begin errors++; $display("FAIL ramp_sum got %0d exp 1240", bus.sum_o); end
    checks++; if (bus.mean_o !== 16'd77) begin errors++; $display("FAIL ramp_mean got %0d exp 77", bus.mean_o); end
  endtask

  task automatic test_full_scale;
    bit seen;
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'd255, 1'b0);
    wait_out(seen);
    checks++; if (!seen) begin errors++; $display("FAIL fs_timeout got 0 exp 1"); end
    checks++; if (bus.sum_o !== 20'd1040400) begin errors++; $display("FAIL fs_sum got %0d exp 1040400", bus.sum_o); end
    checks++; if (bus.mean_o !== 16'd65025) begin errors++; $display("FAIL fs_mean got %0d exp 65025", bus.mean_o); end
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'd0, 1'b0);
  endtask

  task automatic test_back_to_back_overflow;
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'd1, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'd2, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'd0, 1'b0);
    checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid got %0d exp 1", bus.out_valid_o); end
    checks++; if (bus.sum_o !== 20'd64) begin errors++; $display("FAIL b2b_sum got %0d exp 64", bus.sum_o); end
    checks++; if (bus.mean_o !== 16'd4) begin errors++; $display("FAIL b2b_mean got %0d exp 4", bus.mean_o); end
    checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL b2b_ovf got %0d exp 1", bus.overflow_o); end
    bus.out_ready_i = 1'b1;
    cyc(1'b0, 8'd0, 1'b0);
    bus.out_ready_i = 1'b0;
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0d exp 0", bus.out_valid_o); end
    checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL b2b_ovf_sticky got %0d exp 1", bus.overflow_o); end
    bus.out_ready_i = 1'b1;
  endtask

  task automatic test_clear;
    bit bad = 1'b0;
    bit seen;
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'd5, 1'b0);
    cyc(1'b0, 8'd0, 1'b0);
    cyc(1'b0, 8'd0, 1'b0);
    cyc(1'b0, 8'd0, 1'b1);   // sq_valid of the 10th sample is high in this cycle
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'd1, 1'b0);
      if (bus.out_valid_o) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL clr_early got %0d exp 16", bus.sum_o); end
    wait_out(seen);
    checks++; if (!seen) begin errors++; $display("FAIL clr_timeout got 0 exp 1"); end
    checks++; if (bus.sum_o !== 20'd16) begin errors++; $display("FAIL clr_sum got %0d exp 16", bus.sum_o); end
    checks++; if (bus.mean_o !== 16'd1) begin errors++; $display("FAIL clr_mean got %0d exp 1", bus.mean_o); end
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'd0, 1'b0);
  endtask

  task automatic test_mid_window_reset;
    bit seen;
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'd3, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'd0, 1'b0);
    checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL mr_pre_valid got %0d exp 1", bus.out_valid_o); end
    checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL mr_pre_ovf got %0d exp 1", bus.overflow_o); end
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'd3, 1'b0);
    rst = 1'b1;
    cyc(1'b0, 8'd0, 1'b0);
    rst = 1'b0;
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL mr_valid got %0d exp 0", bus.out_valid_o); end
    checks++; if (bus.sum_o !== 20'd0) begin errors++; $display("FAIL mr_sum got %0d exp 0", bus.sum_o); end
    checks++; if (bus.mean_o !== 16'd0) begin errors++; $display("FAIL mr_mean got %0d exp 0", bus.mean_o); end
    checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL mr_ovf got %0d exp 0", bus.overflow_o); end
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'd2, 1'b0);
    wait_out(seen);
    checks++; if (!seen) begin errors++; $display("FAIL mr_timeout got 0 exp 1"); end
    checks++; if (bus.sum_o !== 20'd64) begin errors++; $display("FAIL mr_post_sum got %0d exp 64", bus.sum_o); end
    checks++; if (bus.mean_o !== 16'd4) begin errors++; $display("FAIL mr_post_mean got %0d exp 4", bus.mean_o); end
  endtask

  initial begin
    test_reset;
    test_const3_latency;
    test_ramp_gaps;
    test_full_scale;
    test_back_to_back_overflow;
    test_clear;
    test_mid_window_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
